// File: rtl/ft232_fifo_target_if.sv
// Byte-stream side of the FT232 FIFO target: bytes served to the initiator and bytes received from it.
// Handshake: bs_data_in is taken on any cycle where bs_data_in_valid and bs_data_in_consume are both high; bs_data_out is new whenever bs_data_out_produce is high (no backpressure).
interface ft232_fifo_target_if;
    logic [7:0] bs_data_in;
    logic       bs_data_in_valid;
    logic       bs_data_in_consume;
    logic [7:0] bs_data_out;
    logic       bs_data_out_produce;

    modport master (
        output bs_data_in, bs_data_in_valid,
        input  bs_data_in_consume, bs_data_out, bs_data_out_produce
    );

    modport slave (
        input  bs_data_in, bs_data_in_valid,
        output bs_data_in_consume, bs_data_out, bs_data_out_produce
    );
endinterface

// File: rtl/ft232_fifo_target.sv
// FT232 (FT245-style) FIFO-bus target: serves held bytes to initiator reads and
// emits initiator writes as a byte stream, with precharge gaps and protocol checking.
module ft232_fifo_target #(
    parameter int PRECHARGE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    inout  wire  [7:0]         ft_data,
    output logic               ft_nRXF,
    input  logic               ft_nRD,
    output logic               ft_nTXE,
    input  logic               ft_nWR,
    ft232_fifo_target_if.slave bs,
    output logic               proto_err,
    output logic               ft_data_oe,
    output logic [1:0]         rd_state_dbg,
    output logic [1:0]         wr_state_dbg
);
    typedef enum logic [1:0] {R_EMPTY, R_FULL, R_DRIVE, R_PRE} rd_state_t;
    typedef enum logic [1:0] {W_READY, W_CAPTURE, W_PRE} wr_state_t;

    localparam logic [3:0] PRE_LAST = 4'(PRECHARGE_CYCLES - 1);

    rd_state_t  rd_state;
    wr_state_t  wr_state;
    logic [3:0] rd_cnt;
    logic [3:0] wr_cnt;
    logic [2:0] rd_sync;
    logic [2:0] wr_sync;
    logic [7:0] d_s1;
    logic [7:0] d_s2;
    logic [7:0] d_s3;
    logic [7:0] hold;
    logic       rd_fall;
    logic       rd_rise;
    logic       wr_fall;
    logic       wr_rise;
    logic       consume;
    logic       rd_err;
    logic       wr_err;

    // Edges compare stage 2 against stage 3; d_s3 lines up with stage 3 of the strobe.
    assign rd_fall = rd_sync[2] & ~rd_sync[1];
    assign rd_rise = ~rd_sync[2] & rd_sync[1];
    assign wr_fall = wr_sync[2] & ~wr_sync[1];
    assign wr_rise = ~wr_sync[2] & wr_sync[1];

    assign consume = (rd_state == R_EMPTY) && bs.bs_data_in_valid && !reset;
    assign bs.bs_data_in_consume = consume;

    assign rd_err = rd_fall && ((rd_state == R_EMPTY) || (rd_state == R_PRE) ||
                                ((rd_state == R_FULL) && (wr_state == W_CAPTURE)));
    assign wr_err = wr_fall && ((wr_state == W_PRE) ||
                                ((wr_state == W_READY) && (rd_state == R_DRIVE)));

    assign ft_data      = ft_data_oe ? hold : 8'hzz;
    assign rd_state_dbg = rd_state;
    assign wr_state_dbg = wr_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state               <= R_EMPTY;
            wr_state               <= W_READY;
            rd_cnt                 <= '0;
            wr_cnt                 <= '0;
            rd_sync                <= 3'b111;
            wr_sync                <= 3'b111;
            d_s1                   <= '0;
            d_s2                   <= '0;
            d_s3                   <= '0;
            hold                   <= '0;
            ft_nRXF                <= 1'b1;
            ft_nTXE                <= 1'b1;
            ft_data_oe             <= 1'b0;
            proto_err              <= 1'b0;
            bs.bs_data_out         <= '0;
            bs.bs_data_out_produce <= 1'b0;
        end else begin
            rd_sync                <= {rd_sync[1], rd_sync[0], ft_nRD};
            wr_sync                <= {wr_sync[1], wr_sync[0], ft_nWR};
            d_s1                   <= ft_data;
            d_s2                   <= d_s1;
            d_s3                   <= d_s2;
            proto_err              <= rd_err | wr_err;
            bs.bs_data_out_produce <= 1'b0;

            case (rd_state)
                R_EMPTY: begin
                    ft_nRXF <= 1'b1;
                    if (consume) begin
                        hold     <= bs.bs_data_in;
                        ft_nRXF  <= 1'b0;
                        rd_state <= R_FULL;
                    end
                end
                R_FULL: begin
                    if (rd_fall && (wr_state != W_CAPTURE)) begin
                        ft_data_oe <= 1'b1;
                        rd_state   <= R_DRIVE;
                    end
                end
                R_DRIVE: begin
                    if (rd_rise) begin
                        ft_data_oe <= 1'b0;
                        ft_nRXF    <= 1'b1;
                        hold       <= '0;
                        rd_cnt     <= '0;
                        rd_state   <= R_PRE;
                    end
                end
                R_PRE: begin
                    if (rd_cnt == PRE_LAST) begin
                        rd_state <= R_EMPTY;
                    end else begin
                        rd_cnt <= rd_cnt + 4'd1;
                    end
                end
                default: rd_state <= R_EMPTY;
            endcase

            case (wr_state)
                W_READY: begin
                    ft_nTXE <= 1'b0;
                    if (wr_fall && (rd_state != R_DRIVE)) begin
                        wr_state <= W_CAPTURE;
                    end
                end
                W_CAPTURE: begin
                    if (wr_rise) begin
                        bs.bs_data_out         <= d_s3;
                        bs.bs_data_out_produce <= 1'b1;
                        ft_nTXE                <= 1'b1;
                        wr_cnt                 <= '0;
                        wr_state               <= W_PRE;
                    end
                end
                W_PRE: begin
                    if (wr_cnt == PRE_LAST) begin
                        ft_nTXE  <= 1'b0;
                        wr_state <= W_READY;
                    end else begin
                        wr_cnt <= wr_cnt + 4'd1;
                    end
                end
                default: wr_state <= W_READY;
            endcase
        end
    end
endmodule

// File: tb/tb_ft232_fifo_target.sv
// Self-checking bench for ft232_fifo_target: acts as the FT232 initiator and
// the byte-stream source/sink, checking against in-order byte queues.
module tb_ft232_fifo_target;
    localparam int P = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       ft_nRD;
    logic       ft_nWR;
    logic       tb_oe;
    logic [7:0] tb_data;
    wire  [7:0] ft_data;
    logic       ft_nRXF;
    logic       ft_nTXE;
    logic       proto_err;
    logic       ft_data_oe;
    logic [1:0] rd_state_dbg;
    logic [1:0] wr_state_dbg;

    ft232_fifo_target_if bs_if ();

    assign ft_data = tb_oe ? tb_data : 8'hzz;

    always #5 clk = ~clk;

    ft232_fifo_target #(.PRECHARGE_CYCLES(P)) dut (
        .clk          (clk),
        .reset        (reset),
        .ft_data      (ft_data),
        .ft_nRXF      (ft_nRXF),
        .ft_nRD       (ft_nRD),
        .ft_nTXE      (ft_nTXE),
        .ft_nWR       (ft_nWR),
        .bs           (bs_if.slave),
        .proto_err    (proto_err),
        .ft_data_oe   (ft_data_oe),
        .rd_state_dbg (rd_state_dbg),
        .wr_state_dbg (wr_state_dbg)
    );

    int n_checks = 0;
    int n_fail = 0;
    int consume_cnt = 0;
    int rst_consume = 0;
    int produce_cnt = 0;
    int err_cnt = 0;
    int contention = 0;
    int unexp_produce = 0;
    int rd_underrun = 0;

    logic [7:0] src_q[$];
    logic [7:0] rd_exp_q[$];
    logic [7:0] wr_exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh_src();
        bs_if.bs_data_in_valid = (src_q.size() != 0);
        bs_if.bs_data_in       = (src_q.size() != 0) ? src_q[0] : 8'h00;
    endtask

    task automatic offer(input logic [7:0] b);
        src_q.push_back(b);
        refresh_src();
    endtask

    // One clock: observe pulses mid-cycle, then resume just after the rising edge.
    task automatic tick();
        logic took;
        @(negedge clk);
        took = bs_if.bs_data_in_consume;
        if (took) begin
            if (reset) rst_consume++;
            else consume_cnt++;
        end
        if (bs_if.bs_data_out_produce) begin
            produce_cnt++;
            if (wr_exp_q.size() == 0) unexp_produce++;
            else check("wr_data", 32'(bs_if.bs_data_out), 32'(wr_exp_q.pop_front()));
        end
        if (proto_err) err_cnt++;
        if (ft_data_oe && tb_oe) contention++;
        @(posedge clk);
        #1;
        if (took && src_q.size() != 0) rd_exp_q.push_back(src_q.pop_front());
        refresh_src();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_read(input int hold, input int gap, input logic measure);
        int t;
        int hi;
        t = 0;
        while (ft_nRXF !== 1'b0 && t < 60) begin
            tick();
            t++;
        end
        check("rd_wait_rxf", 32'(ft_nRXF), 32'd0);
        ft_nRD = 1'b0;
        for (int i = 1; i <= hold; i++) begin
            tick();
            if (i == 3) begin
                check("rd_drive", 32'(ft_data_oe), 32'd1);
                if (rd_exp_q.size() != 0) check("rd_early", 32'(ft_data), 32'(rd_exp_q[0]));
            end
        end
        if (rd_exp_q.size() == 0) rd_underrun++;
        else check("rd_data", 32'(ft_data), 32'(rd_exp_q.pop_front()));
        ft_nRD = 1'b1;
        ticks(3);
        check("rd_release", 32'(ft_data_oe), 32'd0);
        check("rd_rxf_hi", 32'(ft_nRXF), 32'd1);
        if (measure) begin
            hi = 0;
            while (ft_nRXF === 1'b1 && hi < 40) begin
                hi++;
                tick();
            end
            check("rd_pre_len", 32'((hi == P) || (hi == P + 1)), 32'd1);
        end
        ticks(gap);
    endtask

    task automatic do_write(input logic [7:0] d, input int hold, input int gap);
        int t;
        int hi;
        t = 0;
        while (ft_nTXE !== 1'b0 && t < 60) begin
            tick();
            t++;
        end
        check("wr_wait_txe", 32'(ft_nTXE), 32'd0);
        tb_data = d;
        tb_oe   = 1'b1;
        wr_exp_q.push_back(d);
        tick();
        ft_nWR = 1'b0;
        ticks(hold);
        ft_nWR = 1'b1;
        ticks(3);
        tb_oe = 1'b0;
        check("wr_produce", 32'(bs_if.bs_data_out_produce), 32'd1);
        check("wr_txe_hi", 32'(ft_nTXE), 32'd1);
        hi = 0;
        while (ft_nTXE === 1'b1 && hi < 40) begin
            hi++;
            tick();
        end
        check("wr_pre_len", 32'(hi), 32'(P));
        ticks(gap);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        int p0;
        int c0;
        logic oe_seen;

        reset   = 1'b1;
        ft_nRD  = 1'b1;
        ft_nWR  = 1'b1;
        tb_oe   = 1'b0;
        tb_data = 8'h00;
        offer(8'hA5);

        // Reset defaults with a byte already offered.
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_rxf", 32'(ft_nRXF), 32'd1);
            check("rst_txe", 32'(ft_nTXE), 32'd1);
            check("rst_z", 32'(ft_data_oe), 32'd0);
            check("rst_proto", 32'(proto_err), 32'd0);
            check("rst_produce", 32'(bs_if.bs_data_out_produce), 32'd0);
            check("rst_out", 32'(bs_if.bs_data_out), 32'd0);
        end
        reset = 1'b0;
        tick();
        check("rst_consume", 32'(rst_consume), 32'd0);
        check("post_rst_consume", 32'(consume_cnt), 32'd1);
        check("post_rst_rxf", 32'(ft_nRXF), 32'd0);
        check("post_rst_txe", 32'(ft_nTXE), 32'd0);
        ticks(4);
        check("single_consume", 32'(consume_cnt), 32'd1);

        // Directed read and write.
        offer(8'h5A);
        do_read(6, 3, 1'b1);
        do_read(6, 3, 1'b0);
        do_write(8'h3C, 6, 2);
        check("wr_out_hold", 32'(bs_if.bs_data_out), 32'h3C);

        // Back-to-back streams in both directions.
        e0 = err_cnt;
        for (int b = 0; b < 256; b++) offer(8'(b));
        for (int b = 0; b < 256; b++) do_read(5, 3, 1'b0);
        for (int b = 0; b < 256; b++) do_write(8'(b), 5, 0);
        check("stream_err", 32'(err_cnt - e0), 32'd0);
        check("stream_contention", 32'(contention), 32'd0);

        // Read strobe with nothing to serve.
        ticks(6);
        check("p1_rxf", 32'(ft_nRXF), 32'd1);
        e0 = err_cnt;
        oe_seen = 1'b0;
        ft_nRD = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            oe_seen = oe_seen | ft_data_oe;
        end
        ft_nRD = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            oe_seen = oe_seen | ft_data_oe;
        end
        check("p1_err", 32'(err_cnt - e0), 32'd1);
        check("p1_z", 32'(oe_seen), 32'd0);

        // Second write strobe landing in the precharge window.
        e0 = err_cnt;
        p0 = produce_cnt;
        tb_data = 8'hC3;
        tb_oe   = 1'b1;
        wr_exp_q.push_back(8'hC3);
        tick();
        ft_nWR = 1'b0;
        ticks(6);
        ft_nWR = 1'b1;
        tick();
        ft_nWR = 1'b0;
        ticks(6);
        ft_nWR = 1'b1;
        tb_oe  = 1'b0;
        ticks(8);
        check("p2_err", 32'(err_cnt - e0), 32'd1);
        check("p2_produce", 32'(produce_cnt - p0), 32'd1);

        // Write strobe while the read is driving the bus.
        offer(8'h77);
        e0 = err_cnt;
        p0 = produce_cnt;
        ticks(4);
        check("p3_rxf", 32'(ft_nRXF), 32'd0);
        ft_nRD = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 3) begin
                check("p3_drive", 32'(ft_data_oe), 32'd1);
                ft_nWR = 1'b0;
            end
            if (i == 5) ft_nWR = 1'b1;
        end
        if (rd_exp_q.size() == 0) rd_underrun++;
        else check("p3_data", 32'(ft_data), 32'(rd_exp_q.pop_front()));
        ft_nRD = 1'b1;
        ticks(3);
        check("p3_release", 32'(ft_data_oe), 32'd0);
        ticks(4);
        check("p3_err", 32'(err_cnt - e0), 32'd1);
        check("p3_produce", 32'(produce_cnt - p0), 32'd0);

        // Randomized mix of reads and writes.
        e0 = err_cnt;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                offer(8'($urandom_range(0, 255)));
                do_read(int'($urandom_range(5, 8)), int'($urandom_range(3, 6)), 1'b0);
            end else begin
                do_write(8'($urandom_range(0, 255)), int'($urandom_range(5, 8)), int'($urandom_range(0, 3)));
            end
        end
        check("rand_err", 32'(err_cnt - e0), 32'd0);

        // Reset while one read is driving and one write is being captured.
        offer(8'h99);
        ticks(6);
        check("mid_rxf", 32'(ft_nRXF), 32'd0);
        check("mid_txe", 32'(ft_nTXE), 32'd0);
        e0 = err_cnt;
        p0 = produce_cnt;
        ft_nRD = 1'b0;
        ft_nWR = 1'b0;
        ticks(4);
        check("mid_drive", 32'(ft_data_oe), 32'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_z", 32'(ft_data_oe), 32'd0);
        check("mid_rst_rxf", 32'(ft_nRXF), 32'd1);
        check("mid_rst_txe", 32'(ft_nTXE), 32'd1);
        ft_nRD = 1'b1;
        ft_nWR = 1'b1;
        ticks(2);
        reset = 1'b0;
        if (rd_exp_q.size() != 0) void'(rd_exp_q.pop_front());
        c0 = consume_cnt;
        ticks(4);
        check("mid_no_produce", 32'(produce_cnt - p0), 32'd0);
        check("mid_no_err", 32'(err_cnt - e0), 32'd0);
        check("mid_txe_ready", 32'(ft_nTXE), 32'd0);
        check("mid_rxf_empty", 32'(ft_nRXF), 32'd1);
        check("mid_no_consume", 32'(consume_cnt - c0), 32'd0);
        offer(8'h42);
        do_read(6, 3, 1'b0);
        do_write(8'hE7, 6, 2);

        check("unexp_produce", 32'(unexp_produce), 32'd0);
        check("rd_underrun", 32'(rd_underrun), 32'd0);
        check("wr_left", 32'(wr_exp_q.size()), 32'd0);
        check("contention", 32'(contention), 32'd0);
        check("rst_consume_total", 32'(rst_consume), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
